// File: rtl/pipeline_debug_unit.sv
// pipeline_debug_unit
//   Byte-stream controller for the MIPS pipeline debug interface. It sits between a UART
//   byte RX/TX pair and the pipeline top. It loads a program word by word, then runs the
//   program continuously or single-steps it. After a run or a step it dumps the PC, the
//   register file and the data memory.
//
//   Commands, accepted only in idle:
//     'L' (0x4C) load
//     'R' (0x52) run
//     'S' (0x53) step
//
// Ports
//   i_clk, i_reset         clock; synchronous active-low reset
//   i_rx_data/i_rx_valid   received byte and its one-cycle strobe
//   o_tx_data/o_tx_valid   byte to transmit, held until i_tx_ready accepts it
//   o_write/o_instruction  one-cycle program-word write to the pipeline
//   o_enable               pipeline clock-enable
//   o_debug_addr           register/memory read address (held outside the dump)
//   i_pc, i_reg, i_mem     pipeline PC, register data and memory data at o_debug_addr
//   i_halt                 pipeline has retired HALT
//   o_busy                 high in every state except idle
//
// Optional feature: define PIPELINE_DEBUG_CYCLE_CNT_EN to count enabled cycles. The count
// is sent as an extra dump word right after the PC.
module pipeline_debug_unit #(
    parameter int unsigned        INST_SZ     = 32,
    parameter int unsigned        DBG_ADDR_SZ = 5,
    parameter int unsigned        IMEM_WORDS  = 64,
    parameter int unsigned        MEM_WORDS   = 32,
    parameter int unsigned        RD_LAT      = 1,
    parameter logic [INST_SZ-1:0] HALT_WORD   = 32'h0000003F
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_write,
    output logic [INST_SZ-1:0]     o_instruction,
    output logic                   o_enable,
    output logic [DBG_ADDR_SZ-1:0] o_debug_addr,
    input  logic [INST_SZ-1:0]     i_pc,
    input  logic [INST_SZ-1:0]     i_reg,
    input  logic [INST_SZ-1:0]     i_mem,
    input  logic                   i_halt,
    output logic                   o_busy
);

    localparam int unsigned            WcW      = $clog2(IMEM_WORDS) + 1;
    localparam logic [1:0]             ByteLast = 2'(INST_SZ / 8 - 1);
    localparam logic [WcW-1:0]         WordLast = WcW'(IMEM_WORDS - 1);
    localparam logic [DBG_ADDR_SZ-1:0] RegLast  = DBG_ADDR_SZ'(31);
    localparam logic [DBG_ADDR_SZ-1:0] MemLast  = DBG_ADDR_SZ'(MEM_WORDS - 1);
    localparam logic [7:0]             LatLast  = 8'(RD_LAT);
    localparam logic [7:0]             CmdLoad  = 8'h4C;
    localparam logic [7:0]             CmdRun   = 8'h52;
    localparam logic [7:0]             CmdStep  = 8'h53;
    localparam logic [7:0]             AckByte  = 8'h4B;

    typedef enum logic [3:0] {
        StIdle, StLoad, StWrite, StAck, StRun, StStep, StStepWait,
        StDumpPc, StDumpAddr, StDumpSend
    } state_e;

    typedef enum logic [1:0] {SecPc, SecCnt, SecReg, SecMem} sec_e;

    state_e                 state_q, state_d;
    sec_e                   sec_q, sec_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [WcW-1:0]         word_cnt_q, word_cnt_d;
    logic [INST_SZ-1:0]     instr_q, instr_d;
    logic [INST_SZ-1:0]     tx_word_q, tx_word_d;
    logic [DBG_ADDR_SZ-1:0] addr_q, addr_d;
    logic [7:0]             lat_q, lat_d;
    logic                   halted_q, halted_d;
`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
    logic [31:0]            cyc_q, cyc_d;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            sec_q      <= SecPc;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            instr_q    <= '0;
            tx_word_q  <= '0;
            addr_q     <= '0;
            lat_q      <= '0;
            halted_q   <= 1'b0;
`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
            cyc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            instr_q    <= instr_d;
            tx_word_q  <= tx_word_d;
            addr_q     <= addr_d;
            lat_q      <= lat_d;
            halted_q   <= halted_d;
`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        instr_d    = instr_q;
        tx_word_d  = tx_word_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        halted_d   = halted_q;
        o_write    = 1'b0;
        o_enable   = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
        cyc_d      = cyc_q;
`endif

        case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CmdLoad: begin
                            state_d    = StLoad;
                            halted_d   = 1'b0;
                            byte_cnt_d = '0;
                            word_cnt_d = '0;
`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
                            cyc_d      = '0;
`endif
                        end
                        CmdRun:  state_d = StRun;
                        CmdStep: state_d = StStep;
                        default: ;
                    endcase
                end
            end
            StLoad: begin
                if (i_rx_valid) begin
                    instr_d    = {instr_q[INST_SZ-9:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == ByteLast) state_d = StWrite;
                end
            end
            StWrite: begin
                // Incoming bytes are deliberately dropped in this cycle.
                o_write    = 1'b1;
                word_cnt_d = word_cnt_q + WcW'(1);
                if (instr_q == HALT_WORD || word_cnt_q == WordLast) state_d = StAck;
                else                                                 state_d = StLoad;
            end
            StAck: begin
                o_tx_valid = 1'b1;
                o_tx_data  = AckByte;
                if (i_tx_ready) state_d = StIdle;
            end
            StRun: begin
                if (halted_q) begin
                    state_d = StDumpPc;
                end else if (i_halt) begin
                    // Enable is gated in the same cycle the halt is seen.
                    halted_d = 1'b1;
                    state_d  = StDumpPc;
                end else begin
                    o_enable = 1'b1;
                end
            end
            StStep: begin
                o_enable = ~halted_q;
                state_d  = StStepWait;
            end
            StStepWait: begin
                if (i_halt) halted_d = 1'b1;
                state_d = StDumpPc;
            end
            StDumpPc: begin
                tx_word_d  = i_pc;
                sec_d      = SecPc;
                byte_cnt_d = '0;
                state_d    = StDumpSend;
            end
            StDumpAddr: begin
                // o_debug_addr changed on entry; the read data is valid RD_LAT cycles later.
                if (lat_q == LatLast) begin
                    tx_word_d  = (sec_q == SecMem) ? i_mem : i_reg;
                    byte_cnt_d = '0;
                    state_d    = StDumpSend;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            StDumpSend: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_word_q[INST_SZ-1 -: 8];
                if (i_tx_ready) begin
                    tx_word_d  = tx_word_q << 8;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == ByteLast) begin
                        lat_d = '0;
                        unique case (sec_q)
                            SecPc: begin
`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
                                sec_d     = SecCnt;
                                tx_word_d = INST_SZ'(cyc_q);
`else
                                sec_d   = SecReg;
                                addr_d  = '0;
                                state_d = StDumpAddr;
`endif
                            end
                            SecCnt: begin
                                sec_d   = SecReg;
                                addr_d  = '0;
                                state_d = StDumpAddr;
                            end
                            SecReg: begin
                                if (addr_q == RegLast) begin
                                    sec_d  = SecMem;
                                    addr_d = '0;
                                end else begin
                                    addr_d = addr_q + DBG_ADDR_SZ'(1);
                                end
                                state_d = StDumpAddr;
                            end
                            SecMem: begin
                                if (addr_q == MemLast) begin
                                    state_d = StIdle;
                                end else begin
                                    addr_d  = addr_q + DBG_ADDR_SZ'(1);
                                    state_d = StDumpAddr;
                                end
                            end
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef PIPELINE_DEBUG_CYCLE_CNT_EN
        if (o_enable) cyc_d = cyc_q + 32'd1;
`endif
    end

    assign o_instruction = instr_q;
    assign o_debug_addr  = addr_q;
    assign o_busy        = (state_q != StIdle);

endmodule

// File: doc/pipeline_debug_unit.md
Name: pipeline_debug_unit

Overview:
- Byte-stream controller that sequences the MIPS pipeline's debug interface.
- Loads a program word-by-word over `o_write`/`o_instruction`, then runs it continuously or single-steps via `o_enable`.
- After a run or step, dumps PC, register file and data memory through `o_debug_addr`.
- Sits between a UART byte RX/TX pair and the pipeline top.

Parameters:
- INST_SZ, 32, instruction/data word width (multiple of 8)
- DBG_ADDR_SZ, 5, width of `o_debug_addr`
- IMEM_WORDS, 64, maximum program length in words
- MEM_WORDS, 32, data-memory words dumped (≤ 2**DBG_ADDR_SZ)
- RD_LAT, 1, cycles from `o_debug_addr` change to valid `i_reg`/`i_mem`
- HALT_WORD, 32'h0000003F, instruction that terminates a load

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-low (asserted when 0)
- i_rx_data  in  8  received command/program byte
- i_rx_valid  in  1  one-cycle strobe, `i_rx_data` valid
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  `o_tx_data` valid; held until accepted
- i_tx_ready  in  1  transmitter accepts the byte when `o_tx_valid & i_tx_ready`
- o_write  out  1  one-cycle pulse, pipeline latches `o_instruction`
- o_instruction  out  INST_SZ  assembled instruction word
- o_enable  out  1  pipeline clock-enable
- o_debug_addr  out  DBG_ADDR_SZ  register/memory read address
- i_pc  in  INST_SZ  pipeline PC
- i_reg  in  INST_SZ  register file data at `o_debug_addr`
- i_mem  in  INST_SZ  data memory at `o_debug_addr`
- i_halt  in  1  pipeline has retired HALT
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (`i_reset` == 0 at a clock edge):
  - All outputs 0; state IDLE; byte/word counters 0; sticky `halted` flag cleared.
  - Takes effect in any state, including mid-load, mid-run and mid-dump. A pending TX byte is dropped.
- Commands, accepted only in IDLE; other `i_rx_valid` bytes are ignored:
  - 0x4C 'L': go to LOAD and clear `halted`.
  - 0x52 'R': go to RUN.
  - 0x53 'S': go to STEP.
  - Any other byte: stay in IDLE.
- LOAD:
  - Bytes are shifted in MSB-first. The 4th byte completes a word.
  - The cycle after a word completes, `o_instruction` = word and `o_write` = 1 for exactly one cycle; word counter increments.
  - Exit to IDLE after writing a word equal to HALT_WORD, or after IMEM_WORDS words, whichever comes first. No bytes are accepted in the write cycle.
  - Ack byte 0x4B is sent on exit.
- RUN:
  - If `halted` is set on entry: `o_enable` stays 0 and the unit goes straight to DUMP.
  - Otherwise `o_enable` = 1 from the next cycle.
  - On the first cycle with `i_halt` = 1: `o_enable` drops that same cycle (combinationally gated), `halted` is set, then DUMP.
- STEP:
  - `o_enable` = 1 for exactly one cycle, unless `halted` is set.
  - `halted` is set if `i_halt` is 1 in the cycle after the step.
  - Then DUMP.
- DUMP sequence, each word sent as 4 bytes MSB-first:
  - PC: `i_pc` sampled on DUMP entry.
  - REG: for a = 0..31, drive `o_debug_addr` = a, wait RD_LAT cycles, capture `i_reg`, send.
  - MEM: for a = 0..MEM_WORDS-1, same procedure with `i_mem`.
  - After the last byte is accepted, return to IDLE.
  - Total bytes = 4 + 128 + 4·MEM_WORDS (260 by default).
- TX handshake:
  - `o_tx_data` is stable while `o_tx_valid` is high.
  - The next byte is presented no earlier than the cycle after acceptance.
  - Back-pressure (`i_tx_ready` = 0) stalls the dump indefinitely; `o_enable` stays 0 throughout DUMP.
- `o_debug_addr` is held at its last value outside DUMP.
- Widths: byte counter 2 bits, wraps 3→0; word counter `$clog2(IMEM_WORDS)+1` bits.

Optional Feature:
- Macro: PIPELINE_DEBUG_CYCLE_CNT_EN.
- Defined:
  - 32-bit cycle counter increments on every cycle with `o_enable` = 1; cleared on reset and on 'L'.
  - Counter is sent as one extra word right after PC; dump becomes 264 bytes.
- Undefined: no counter logic; dump layout as above.

Test Plan:
- Reset mid-LOAD: after 2 bytes of a word, drive `i_reset` = 0 for one cycle -> all outputs 0, IDLE. Subsequent 'L' + 4 bytes 0x20020002 gives one `o_write` with `o_instruction` = 0x20020002.
- Load 'L' + words 0x20020002, 0xAC020002, 0x0000003F -> exactly 3 `o_write` pulses with those values, then TX byte 0x4B, `o_busy` = 0. A 4th word sent afterwards causes no write.
- 'R' with `i_halt` asserted after 10 enabled cycles -> `o_enable` high exactly 10 cycles, then 260 TX bytes. First 4 bytes = `i_pc` MSB-first; bytes 4..7 = `i_reg` at addr 0.
- 'S' twice -> each gives a single-cycle `o_enable` pulse and a full 260-byte dump. 'S' after halt -> no `o_enable` pulse, dump only.
- Hold `i_tx_ready` = 0 for 50 cycles mid-dump -> `o_tx_data` stable, `o_tx_valid` held high, no byte lost or duplicated.
- With PIPELINE_DEBUG_CYCLE_CNT_EN: 'R' with halt after 10 enabled cycles -> dump word 1 = 0x0000000A, 264 bytes total.
